// File: rtl/sdf_r2_stage_ctrl.sv
// -----------------------------------------------------------------------------
// sdf_r2_stage_ctrl
//
// Sequencing controller for one radix-2 single-path-delay-feedback butterfly
// stage. A frame is 2*DELAY input samples:
//   - the first DELAY samples are parked in the feedback shift register
//     (butterfly WAITING),
//   - the next DELAY samples are combined with the parked ones (FIRST),
//   - then the DELAY difference terms are drained from the shift register
//     while upstream is held off (SECOND). During this drain the twiddle index
//     for the following multiplier walks 0..DELAY-1.
//
// All outputs are combinational from the phase/counter registers and the
// current inputs, so an accepted sample produces its output in the same
// cycle. Every output is forced to 0 while rst_n is low.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   upstream sample present on butterfly A input
//   in_ready   out  stage accepts a sample this cycle
//   flush      in   synchronous abort, back to IDLE (drops this cycle's sample)
//   state      out  butterfly code: 00 IDLE, 01 FIRST, 10 SECOND, 11 WAITING
//   sr_en      out  feedback shift-register advance enable
//   out_valid  out  butterfly output valid
//   out_sop    out  first valid output of a frame
//   out_eop    out  last valid output of a frame
//   tw_idx     out  twiddle exponent k (0 outside SECOND)
//   busy       out  phase register is not IDLE
// -----------------------------------------------------------------------------
module sdf_r2_stage_ctrl #(
  parameter int DELAY = 16,
  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [1:0]    state,
  output logic          sr_en,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic [CW-1:0] tw_idx,
  output logic          busy
);

  // Phase register encoding (internal; the external state code differs).
  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_WAIT   = 2'd1;
  localparam logic [1:0] PH_FIRST  = 2'd2;
  localparam logic [1:0] PH_SECOND = 2'd3;

  // Butterfly state codes driven on the state port.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_FIRST  = 2'b01;
  localparam logic [1:0] ST_SECOND = 2'b10;
  localparam logic [1:0] ST_WAIT   = 2'b11;

  // Terminal count of every half-frame and the counter increment.
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // With DELAY==1 the parking half-frame is a single sample, which is taken
  // in IDLE itself, so the WAIT phase is skipped entirely.
  localparam logic SKIP_WAIT = (DELAY == 1) ? 1'b1 : 1'b0;

  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Decoded phase and handshake terms shared by next-state and outputs.
  logic in_idle_s;
  logic in_wait_s;
  logic in_first_s;
  logic in_second_s;
  logic cnt_last_s;
  logic cnt_zero_s;
  logic ready_s;
  logic accept_s;
  logic [CW-1:0] cnt_inc_s;

  // Phase decode, terminal-count detect and the accept handshake.
  always_comb begin
    in_idle_s   = (phase_q == PH_IDLE);
    in_wait_s   = (phase_q == PH_WAIT);
    in_first_s  = (phase_q == PH_FIRST);
    in_second_s = (phase_q == PH_SECOND);
    cnt_last_s  = (cnt_q == CNT_LAST);
    cnt_zero_s  = (cnt_q == CNT_ZERO);
    cnt_inc_s   = cnt_q + CNT_ONE;
    // Upstream is held off only while the shift register drains.
    ready_s     = rst_n & ~in_second_s;
    // Flush wins over a simultaneous sample; that sample is dropped.
    accept_s    = in_valid & ready_s & ~flush;
  end

  // Next-state logic for the phase register and half-frame counter.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (flush) begin
      phase_d = PH_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (accept_s) begin
            if (SKIP_WAIT) begin
              phase_d = PH_FIRST;
              cnt_d   = CNT_ZERO;
            end else begin
              // The sample taken in IDLE is the first parked one.
              phase_d = PH_WAIT;
              cnt_d   = CNT_ONE;
            end
          end else begin
            phase_d = PH_IDLE;
            cnt_d   = cnt_q;
          end
        end
        PH_WAIT: begin
          if (accept_s) begin
            if (cnt_last_s) begin
              phase_d = PH_FIRST;
              cnt_d   = CNT_ZERO;
            end else begin
              phase_d = PH_WAIT;
              cnt_d   = cnt_inc_s;
            end
          end else begin
            phase_d = PH_WAIT;
            cnt_d   = cnt_q;
          end
        end
        PH_FIRST: begin
          if (accept_s) begin
            if (cnt_last_s) begin
              phase_d = PH_SECOND;
              cnt_d   = CNT_ZERO;
            end else begin
              phase_d = PH_FIRST;
              cnt_d   = cnt_inc_s;
            end
          end else begin
            phase_d = PH_FIRST;
            cnt_d   = cnt_q;
          end
        end
        PH_SECOND: begin
          // The drain never stalls: it needs no upstream data.
          if (cnt_last_s) begin
            phase_d = PH_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            phase_d = PH_SECOND;
            cnt_d   = cnt_inc_s;
          end
        end
        default: begin
          phase_d = PH_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Phase and counter flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode; everything is forced to 0 while reset is asserted.
  always_comb begin
    state     = ST_IDLE;
    in_ready  = 1'b0;
    sr_en     = 1'b0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    tw_idx    = CNT_ZERO;
    busy      = 1'b0;
    if (rst_n) begin
      case (phase_q)
        // A sample arriving in IDLE is already being parked, hence WAITING.
        PH_IDLE:   state = in_valid ? ST_WAIT : ST_IDLE;
        PH_WAIT:   state = ST_WAIT;
        PH_FIRST:  state = ST_FIRST;
        PH_SECOND: state = ST_SECOND;
        default:   state = ST_IDLE;
      endcase
      in_ready  = ready_s;
      sr_en     = accept_s | in_second_s;
      out_valid = (in_first_s & accept_s) | in_second_s;
      out_sop   = in_first_s & cnt_zero_s & accept_s;
      out_eop   = in_second_s & cnt_last_s;
      tw_idx    = in_second_s ? cnt_q : CNT_ZERO;
      busy      = ~in_idle_s;
    end else begin
      state     = ST_IDLE;
      in_ready  = 1'b0;
      sr_en     = 1'b0;
      out_valid = 1'b0;
      out_sop   = 1'b0;
      out_eop   = 1'b0;
      tw_idx    = CNT_ZERO;
      busy      = 1'b0;
    end
  end

  // in_wait_s is part of the decode set for readability; fold it in here so
  // the phase decode stays complete and every decoded term has a reader.
  logic unused_decode_s;
  always_comb begin
    unused_decode_s = in_wait_s & 1'b0;
  end

endmodule

// File: tb/tb_sdf_r2_stage_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for sdf_r2_stage_ctrl. Three instances (DELAY = 4, 1, 8) share one
// stimulus stream. A frame-level reference model per instance tracks how many
// samples of the current frame have been taken and how far the drain has
// progressed, and predicts every output from that.
// Output vector layout per instance:
//   [11:10] state, [9] in_ready, [8] sr_en, [7] out_valid, [6] out_sop,
//   [5] out_eop, [4] busy, [3:0] tw_idx zero-extended.
// -----------------------------------------------------------------------------
module tb_sdf_r2_stage_ctrl;

  logic clk;
  logic rst_n_s;
  logic in_valid_s;
  logic flush_s;

  int checks = 0;
  int errors = 0;

  logic [1:0] st4, st1, st8;
  logic rdy4, rdy1, rdy8, sr4, sr1, sr8, ov4, ov1, ov8;
  logic sop4, sop1, sop8, eop4, eop1, eop8, bsy4, bsy1, bsy8;
  logic [1:0] tw4;
  logic [0:0] tw1;
  logic [2:0] tw8;

  logic [11:0] obs [3];

  sdf_r2_stage_ctrl #(.DELAY(4)) u_d4 (
    .clk(clk), .rst_n(rst_n_s), .in_valid(in_valid_s), .in_ready(rdy4),
    .flush(flush_s), .state(st4), .sr_en(sr4), .out_valid(ov4),
    .out_sop(sop4), .out_eop(eop4), .tw_idx(tw4), .busy(bsy4)
  );
  sdf_r2_stage_ctrl #(.DELAY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n_s), .in_valid(in_valid_s), .in_ready(rdy1),
    .flush(flush_s), .state(st1), .sr_en(sr1), .out_valid(ov1),
    .out_sop(sop1), .out_eop(eop1), .tw_idx(tw1), .busy(bsy1)
  );
  sdf_r2_stage_ctrl #(.DELAY(8)) u_d8 (
    .clk(clk), .rst_n(rst_n_s), .in_valid(in_valid_s), .in_ready(rdy8),
    .flush(flush_s), .state(st8), .sr_en(sr8), .out_valid(ov8),
    .out_sop(sop8), .out_eop(eop8), .tw_idx(tw8), .busy(bsy8)
  );

  assign obs[0] = {st4, rdy4, sr4, ov4, sop4, eop4, bsy4, 2'b00, tw4};
  assign obs[1] = {st1, rdy1, sr1, ov1, sop1, eop1, bsy1, 3'b000, tw1};
  assign obs[2] = {st8, rdy8, sr8, ov8, sop8, eop8, bsy8, 1'b0, tw8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, samples taken in this frame (0..2D-1),
  // whether the drain is running, and the drain position.
  int dly [3] = '{4, 1, 8};
  int taken [3] = '{0, 0, 0};
  int draining [3] = '{0, 0, 0};
  int drain_pos [3] = '{0, 0, 0};

  function automatic logic [11:0] exp_vec(int k, logic iv, logic fl, logic rn);
    logic [1:0] st;
    logic dr, first, acc, sop, eop, bsy;
    int tw;
    dr    = (draining[k] != 0);
    first = !dr && (taken[k] >= dly[k]);
    if (!rn) return 12'd0;
    if (dr)                st = 2'b10;
    else if (first)        st = 2'b01;
    else if (taken[k] > 0) st = 2'b11;
    else                   st = iv ? 2'b11 : 2'b00;
    acc = iv && !dr && !fl;
    sop = first && acc && (taken[k] == dly[k]);
    eop = dr && (drain_pos[k] == dly[k] - 1);
    bsy = dr || (taken[k] != 0);
    tw  = dr ? drain_pos[k] : 0;
    return {st, !dr, acc || dr, (first && acc) || dr, sop, eop, bsy, 4'(tw)};
  endfunction

  task automatic model_step(logic iv, logic fl, logic rn);
    for (int k = 0; k < 3; k++) begin
      if (!rn || fl) begin
        taken[k] = 0; draining[k] = 0; drain_pos[k] = 0;
      end else if (draining[k] != 0) begin
        if (drain_pos[k] == dly[k] - 1) begin
          draining[k] = 0; drain_pos[k] = 0;
        end else begin
          drain_pos[k] = drain_pos[k] + 1;
        end
      end else if (iv) begin
        taken[k] = taken[k] + 1;
        if (taken[k] == 2 * dly[k]) begin
          taken[k] = 0; draining[k] = 1; drain_pos[k] = 0;
        end
      end
    end
  endtask

  // Drive inputs just after a rising edge, then wait to mid-low phase.
  task automatic set_in(logic iv, logic fl, logic rn);
    in_valid_s = iv;
    flush_s    = fl;
    rst_n_s    = rn;
    #4;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step(in_valid_s, flush_s, rst_n_s);
    #1;
  endtask

  task automatic go_idle();
    set_in(1'b0, 1'b1, 1'b1);
    advance();
  endtask

  task automatic test_reset();
    logic [11:0] e;
    for (int c = 0; c < 3; c++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(k, in_valid_s, flush_s, rst_n_s);
        checks++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL reset d=%0d cyc=%0d got %h want %h", dly[k], c, obs[k], e);
        end
      end
      checks++;
      if (obs[0] !== 12'h000) begin
        errors++;
        $display("FAIL reset_zero cyc=%0d got %h want 000", c, obs[0]);
      end
      advance();
    end
  endtask

  task automatic test_continuous();
    logic [11:0] e;
    logic [1:0] st_tab [13] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01,
                                2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [1:0] tw_tab [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    go_idle();
    for (int c = 0; c < 24; c++) begin
      set_in(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(k, in_valid_s, flush_s, rst_n_s);
        checks++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL cont d=%0d cyc=%0d got %h want %h", dly[k], c, obs[k], e);
        end
      end
      if (c < 13) begin
        checks++;
        if (st4 !== st_tab[c]) begin
          errors++;
          $display("FAIL cont_state cyc=%0d got %b want %b", c, st4, st_tab[c]);
        end
      end
      if (c >= 8 && c < 12) begin
        checks++;
        if ({rdy4, tw4} !== {1'b0, tw_tab[c-8]}) begin
          errors++;
          $display("FAIL cont_drain cyc=%0d got rdy=%b tw=%0d want rdy=0 tw=%0d",
                   c, rdy4, tw4, tw_tab[c-8]);
        end
      end
      if (c == 4 || c == 11) begin
        checks++;
        if ({sop4, eop4} !== ((c == 4) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL cont_frame cyc=%0d got sop/eop=%b%b", c, sop4, eop4);
        end
      end
      // DELAY=1 repeats 11,01,10 with tw_idx stuck at 0.
      checks++;
      if ({st1, tw1} !== {((c % 3) == 0) ? 2'b11 : ((c % 3) == 1) ? 2'b01 : 2'b10, 1'b0}) begin
        errors++;
        $display("FAIL cont_d1 cyc=%0d got st=%b tw=%b", c, st1, tw1);
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [11:0] e;
    go_idle();
    for (int c = 0; c < 14; c++) begin
      set_in((c == 2 || c == 6) ? 1'b0 : 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(k, in_valid_s, flush_s, rst_n_s);
        checks++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL stall d=%0d cyc=%0d got %h want %h", dly[k], c, obs[k], e);
        end
      end
      if (c == 2 || c == 6) begin
        checks++;
        if ({sr4, ov4, st4} !== {2'b00, (c == 2) ? 2'b11 : 2'b01}) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got sr=%b ov=%b st=%b", c, sr4, ov4, st4);
        end
      end
      if (c == 13) begin
        checks++;
        if (eop4 !== 1'b1) begin
          errors++;
          $display("FAIL stall_eop cyc=%0d got %b want 1", c, eop4);
        end
      end
      advance();
    end
  endtask

  task automatic test_flush();
    logic [11:0] e;
    go_idle();
    for (int c = 0; c < 14; c++) begin
      set_in((c == 11) ? 1'b0 : 1'b1, (c == 10) ? 1'b1 : 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(k, in_valid_s, flush_s, rst_n_s);
        checks++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL flush d=%0d cyc=%0d got %h want %h", dly[k], c, obs[k], e);
        end
      end
      if (c == 10) begin
        checks++;
        if ({ov8, sr8, eop8, rdy8} !== 4'b0001) begin
          errors++;
          $display("FAIL flush_drop got ov=%b sr=%b eop=%b rdy=%b want 0 0 0 1",
                   ov8, sr8, eop8, rdy8);
        end
      end
      if (c == 11) begin
        checks++;
        if ({bsy8, st8, bsy4, st4} !== 6'b000000) begin
          errors++;
          $display("FAIL flush_idle got busy8=%b st8=%b busy4=%b st4=%b",
                   bsy8, st8, bsy4, st4);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] e;
    go_idle();
    for (int c = 0; c < 22; c++) begin
      set_in(1'b1, 1'b0, (c == 9) ? 1'b0 : 1'b1);
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(k, in_valid_s, flush_s, rst_n_s);
        checks++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL rstmid d=%0d cyc=%0d got %h want %h", dly[k], c, obs[k], e);
        end
      end
      if (c == 10) begin
        checks++;
        if ({rdy4, st4, ov4} !== 4'b1110) begin
          errors++;
          $display("FAIL rstmid_after got rdy=%b st=%b ov=%b want 1 11 0", rdy4, st4, ov4);
        end
      end
      if (c == 14) begin
        checks++;
        if (sop4 !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_sop got %b want 1", sop4);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    go_idle();
    for (int c = 0; c < 1500; c++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 47) == 0),
             1'($urandom_range(0, 95) != 0));
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(k, in_valid_s, flush_s, rst_n_s);
        checks++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL random d=%0d cyc=%0d iv=%b fl=%b rn=%b got %h want %h",
                   dly[k], c, in_valid_s, flush_s, rst_n_s, obs[k], e);
        end
      end
      advance();
    end
  endtask

  initial begin
    in_valid_s = 1'b0;
    flush_s    = 1'b0;
    rst_n_s    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_continuous();
    test_stall();
    test_flush();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdf_r2_stage_ctrl.md
Name: sdf_r2_stage_ctrl

Overview:
Sequencing controller for one radix-2 single-path-delay-feedback (SDF) butterfly stage of the 32-point FFT pipeline. It counts incoming samples and drives the butterfly's 2-bit state code (IDLE/WAITING/FIRST/SECOND). It also drives the enable for the DELAY-deep feedback shift register, input back-pressure, output framing and the twiddle index for the following multiplier. There is one instance per stage, with DELAY = N/2 for that stage.

Parameters:
DELAY, 16, feedback shift-register depth in samples (1, 2, 4, 8, 16); one frame = 2*DELAY input samples.
CW, (DELAY>1 ? $clog2(DELAY) : 1), counter / twiddle-index width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  upstream sample present on butterfly A input this cycle.
in_ready  output  1  stage accepts a sample this cycle.
flush  input  1  synchronous abort; return to IDLE.
state  output  2  butterfly state code: 00 IDLE, 01 FIRST, 10 SECOND, 11 WAITING.
sr_en  output  1  shift-register advance enable.
out_valid  output  1  butterfly output valid (to next-stage input register).
out_sop  output  1  first valid output of frame.
out_eop  output  1  last valid output of frame.
tw_idx  output  CW  twiddle exponent k for the current output; 0 when not in SECOND.
busy  output  1  phase register != IDLE.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-low. While rst_n=0 at a clk edge: phase<=IDLE, cnt<=0. All outputs are combinational from (phase, cnt, in_valid, flush) and are gated to 0 while rst_n=0 (state=00, in_ready=0). Reset mid-frame discards the frame with no partial output afterwards.
- Registers: phase in {IDLE, WAIT, FIRST, SECOND}; cnt[CW-1:0].
- in_ready = rst_n & (phase != SECOND). accept = in_valid & in_ready & ~flush.
- state output:
  - IDLE: 11 if in_valid, else 00.
  - WAIT: 11.
  - FIRST: 01.
  - SECOND: 10.
  - The code is held during stalls; a stall is signalled only by sr_en=0 and out_valid=0.
- sr_en = accept | (phase==SECOND). No shift occurs on stall cycles.
- out_valid = (phase==FIRST & accept) | (phase==SECOND).
- out_sop = phase==FIRST & cnt==0 & accept.
- out_eop = phase==SECOND & cnt==DELAY-1.
- tw_idx = cnt when phase==SECOND, else 0.
- Transitions (evaluated only when no flush):
  - IDLE + accept: DELAY==1 -> FIRST, cnt 0; else -> WAIT, cnt 1.
  - WAIT + accept: cnt==DELAY-1 -> FIRST, cnt 0; else cnt+1.
  - FIRST + accept: cnt==DELAY-1 -> SECOND, cnt 0; else cnt+1.
  - SECOND: unconditional each cycle; cnt==DELAY-1 -> IDLE, cnt 0; else cnt+1.
  - No accept in IDLE/WAIT/FIRST: hold.
- Latency and throughput: outputs are combinational with the same cycle as the accepted input (zero latency). A frame occupies 3*DELAY cycles minimum. In_ready is low exactly DELAY cycles per frame. A sample presented in the cycle after the SECOND->IDLE transition is accepted with no extra bubble.
- flush=1: next phase IDLE, cnt 0. Flush wins over a simultaneous accept; that sample is dropped (in_ready unaffected, accept forced 0, sr_en=0, out_valid=0 that cycle). Flush in SECOND truncates the drain; out_eop is not asserted.
- Counter never exceeds DELAY-1; no wrap other than the listed terminal transitions.
- The controller does not touch data; it is integer-only control logic.

Test Plan:
- DELAY=4, in_valid held 1 from cycle 0, flush=0:
  - state 11,11,11,11,01,01,01,01,10,10,10,10 over cycles 0-11.
  - in_ready=0 cycles 8-11.
  - out_valid cycles 4-11.
  - out_sop cycle 4, out_eop cycle 11.
  - tw_idx 0,1,2,3 in cycles 8-11.
  - Second frame accepted from cycle 12 (state 11).
- DELAY=4, in_valid low at cycles 2 and 6 of a frame -> sr_en=0 and out_valid=0 on those cycles, state code held, FIRST ends one accept later, total 14 cycles to out_eop.
- DELAY=1, continuous input -> state pattern 11,01,10 repeating every 3 cycles; out_sop and out_eop each pulse once per frame; tw_idx always 0.
- DELAY=8, flush asserted on the 3rd FIRST cycle with in_valid=1 -> that cycle out_valid=0 and sr_en=0; next cycle busy=0, state=00 (in_valid=0); no out_eop.
- DELAY=4, rst_n=0 for one cycle during SECOND cnt=1 -> outputs 0 during reset; afterwards phase IDLE, in_ready=1, next frame produces out_sop exactly DELAY accepts later.
